// File: rtl/regfile_np_if.sv
//==============================================================================
// Module      : regfile_np_if
// Description : Write-port and read-port bundle for the regfile_np register file.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface regfile_np_if #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 32,
    parameter int NRD   = 2
);
    localparam int AW = $clog2(DEPTH);

    logic                      wr_en;
    logic [AW-1:0]             wr_addr;
    logic [WIDTH-1:0]          wr_data;
    logic [NRD-1:0][AW-1:0]    rd_addr;
    logic [NRD-1:0][WIDTH-1:0] rd_data;

    modport master (
        output wr_en, wr_addr, wr_data, rd_addr,
        input  rd_data
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_addr,
        output rd_data
    );
endinterface

`default_nettype wire

// File: rtl/regfile_np.sv
//==============================================================================
// Module      : regfile_np
// Description : DEPTH x WIDTH register file, one synchronous write port, NRD
//               combinational mux-tree read ports, hardwired zero register.
//               Define REGFILE_BYPASS_EN for write-through forwarding.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module regfile_np #(
    parameter int WIDTH    = 64,
    parameter int DEPTH    = 32,
    parameter int NRD      = 2,
    parameter int ZERO_IDX = 31
) (
    input  wire logic        clk,
    input  wire logic        reset,
    regfile_np_if.slave      bus
);
    localparam int            AW         = $clog2(DEPTH);
    localparam bit            c_HAS_ZERO = (ZERO_IDX >= 0) && (ZERO_IDX < DEPTH);
    localparam logic [AW-1:0] c_ZADDR    = AW'(ZERO_IDX);

    logic [WIDTH-1:0]          r_mem [DEPTH];
    logic                      w_wr_zero;
    logic                      w_wr_ok;
    logic [NRD-1:0][WIDTH-1:0] w_rd_data;

    assign w_wr_zero = c_HAS_ZERO && (bus.wr_addr == c_ZADDR);
    assign w_wr_ok   = bus.wr_en && !w_wr_zero;

    // Reset has priority over a concurrent write.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_ok) begin
            r_mem[bus.wr_addr] <= bus.wr_data;
        end
    end

    generate
        for (genvar p = 0; p < NRD; p++) begin : g_rd
            logic [WIDTH-1:0] w_node [DEPTH];
            logic [WIDTH-1:0] w_port;
            logic             w_rd_zero;

            assign w_rd_zero = c_HAS_ZERO && (bus.rd_addr[p] == c_ZADDR);

            // Level l folds pairs of nodes using address bit l; node 0 ends as the result.
            always_comb begin
                for (int i = 0; i < DEPTH; i++) begin
                    w_node[i] = r_mem[i];
                end
                for (int l = 0; l < AW; l++) begin
                    for (int i = 0; i < (DEPTH >> (l + 1)); i++) begin
                        w_node[i] = bus.rd_addr[p][l] ? w_node[2*i+1] : w_node[2*i];
                    end
                end
            end

`ifdef REGFILE_BYPASS_EN
            logic w_byp;
            assign w_byp  = w_wr_ok && !reset && (bus.rd_addr[p] == bus.wr_addr);
            assign w_port = w_rd_zero ? '0 : (w_byp ? bus.wr_data : w_node[0]);
`else
            assign w_port = w_rd_zero ? '0 : w_node[0];
`endif
            assign w_rd_data[p] = w_port;
        end
    endgenerate

    assign bus.rd_data = w_rd_data;
endmodule

`default_nettype wire

// File: tb/tb_regfile_np.sv
//==============================================================================
// Module      : tb_regfile_np
// Description : Directed, table-driven bench for regfile_np (default and 32x16x3).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_regfile_np;
    logic clk;
    logic reset;

    int n_checks = 0;
    int n_errors = 0;

    regfile_np_if #(.WIDTH(64), .DEPTH(32), .NRD(2)) bus_a ();
    regfile_np_if #(.WIDTH(32), .DEPTH(16), .NRD(3)) bus_b ();

    regfile_np #(.WIDTH(64), .DEPTH(32), .NRD(2), .ZERO_IDX(31)) u_dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a.slave)
    );

    regfile_np #(.WIDTH(32), .DEPTH(16), .NRD(3), .ZERO_IDX(16)) u_dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [63:0] wd;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [63:0] e0;
        logic [63:0] e1;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_a(input logic [4:0] a, input logic [63:0] d);
        bus_a.wr_en   = 1'b1;
        bus_a.wr_addr = a;
        bus_a.wr_data = d;
        tick();
        bus_a.wr_en   = 1'b0;
    endtask

    logic [63:0] exp_v;
    logic [31:0] exp_w;

    initial begin
        vecs[0] = '{1'b1, 5'd10, 64'h111, 5'd10, 5'd11, 64'h111, 64'd11001};
        vecs[1] = '{1'b1, 5'd10, 64'h222, 5'd10, 5'd10, 64'h222, 64'h222};
        vecs[2] = '{1'b0, 5'd10, 64'h333, 5'd10, 5'd0,  64'h222, 64'd1};
        vecs[3] = '{1'b1, 5'd31, 64'h444, 5'd31, 5'd10, 64'd0,   64'h222};
        vecs[4] = '{1'b1, 5'd0,  64'h555, 5'd0,  5'd30, 64'h555, 64'd30001};
        vecs[5] = '{1'b1, 5'd30, '1,      5'd30, 5'd0,  '1,      64'h555};

        reset = 1'b1;
        bus_a.wr_en = 1'b0; bus_a.wr_addr = '0; bus_a.wr_data = '0; bus_a.rd_addr = '0;
        bus_b.wr_en = 1'b0; bus_b.wr_addr = '0; bus_b.wr_data = '0; bus_b.rd_addr = '0;
        tick();
        tick();
        reset = 1'b0;

        bus_a.rd_addr[0] = 5'd3; bus_a.rd_addr[1] = 5'd5; #1;
        check("reset_state_p0", bus_a.rd_data[0], 64'd0);
        check("reset_state_p1", bus_a.rd_data[1], 64'd0);

        // Reset clear with a concurrent write that must be cancelled
        write_a(5'd3, 64'hDEAD);
        check("preload_3", bus_a.rd_data[0], 64'hDEAD);
        reset = 1'b1;
        bus_a.wr_en = 1'b1; bus_a.wr_addr = 5'd5; bus_a.wr_data = 64'd7;
        tick();
        reset = 1'b0; bus_a.wr_en = 1'b0;
        check("rst_clear_p0_a3", bus_a.rd_data[0], 64'd0);
        check("rst_clear_p1_a5", bus_a.rd_data[1], 64'd0);
        bus_a.rd_addr[0] = 5'd5; bus_a.rd_addr[1] = 5'd3; #1;
        check("rst_clear_p0_a5", bus_a.rd_data[0], 64'd0);
        check("rst_clear_p1_a3", bus_a.rd_data[1], 64'd0);

        // Full sweep
        for (int k = 0; k < 31; k++) write_a(5'(k), 64'(k) * 64'd1000 + 64'd1);
        for (int i = 0; i < 32; i++) begin
            bus_a.rd_addr[0] = 5'(i);
            bus_a.rd_addr[1] = 5'(31 - i);
            #1;
            exp_v = (i == 31) ? 64'd0 : 64'(i) * 64'd1000 + 64'd1;
            check($sformatf("sweep_p0_%0d", i), bus_a.rd_data[0], exp_v);
            exp_v = (i == 0) ? 64'd0 : 64'(31 - i) * 64'd1000 + 64'd1;
            check($sformatf("sweep_p1_%0d", 31 - i), bus_a.rd_data[1], exp_v);
        end

        // Zero register: in-cycle and after the edge
        bus_a.rd_addr[0] = 5'd31; bus_a.rd_addr[1] = 5'd31;
        bus_a.wr_en = 1'b1; bus_a.wr_addr = 5'd31; bus_a.wr_data = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        check("zero_in_cycle_p0", bus_a.rd_data[0], 64'd0);
        check("zero_in_cycle_p1", bus_a.rd_data[1], 64'd0);
        tick();
        bus_a.wr_en = 1'b0; #1;
        check("zero_after_p0", bus_a.rd_data[0], 64'd0);
        check("zero_after_p1", bus_a.rd_data[1], 64'd0);

        // Same-cycle read and write of one address
        write_a(5'd4, 64'd10);
        bus_a.rd_addr[0] = 5'd4;
        bus_a.wr_en = 1'b1; bus_a.wr_addr = 5'd4; bus_a.wr_data = 64'd99;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("rw_same_before", bus_a.rd_data[0], 64'd99);
`else
        check("rw_same_before", bus_a.rd_data[0], 64'd10);
`endif
        tick();
        bus_a.wr_en = 1'b0; #1;
        check("rw_same_after", bus_a.rd_data[0], 64'd99);

        // Port independence
        write_a(5'd7, 64'd538129);
        bus_a.rd_addr[0] = 5'd7; bus_a.rd_addr[1] = 5'd7; #1;
        check("indep_p0_a7", bus_a.rd_data[0], 64'd538129);
        check("indep_p1_a7", bus_a.rd_data[1], 64'd538129);
        bus_a.rd_addr[0] = 5'd2; #1;
        check("indep_p0_a2", bus_a.rd_data[0], 64'd2001);
        check("indep_p1_hold", bus_a.rd_data[1], 64'd538129);

        // Table: post-edge values, identical with or without forwarding
        for (int v = 0; v < 6; v++) begin
            bus_a.wr_en      = vecs[v].we;
            bus_a.wr_addr    = vecs[v].wa;
            bus_a.wr_data    = vecs[v].wd;
            bus_a.rd_addr[0] = vecs[v].ra0;
            bus_a.rd_addr[1] = vecs[v].ra1;
            tick();
            check($sformatf("vec%0d_p0", v), bus_a.rd_data[0], vecs[v].e0);
            check($sformatf("vec%0d_p1", v), bus_a.rd_data[1], vecs[v].e1);
        end
        bus_a.wr_en = 1'b0;

        // Second configuration: zero register disabled, all 16 entries writable
        for (int k = 0; k < 16; k++) begin
            bus_b.wr_en   = 1'b1;
            bus_b.wr_addr = 4'(k);
            bus_b.wr_data = 32'(k * 1000 + 1);
            tick();
        end
        bus_b.wr_en = 1'b0;
        for (int i = 0; i < 16; i++) begin
            bus_b.rd_addr[0] = 4'(i);
            bus_b.rd_addr[1] = 4'(15 - i);
            bus_b.rd_addr[2] = 4'(i);
            #1;
            exp_w = 32'(i * 1000 + 1);
            check($sformatf("b_sweep_p0_%0d", i), 64'(bus_b.rd_data[0]), 64'(exp_w));
            check($sformatf("b_sweep_p2_%0d", i), 64'(bus_b.rd_data[2]), 64'(exp_w));
            exp_w = 32'((15 - i) * 1000 + 1);
            check($sformatf("b_sweep_p1_%0d", 15 - i), 64'(bus_b.rd_data[1]), 64'(exp_w));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/regfile_np.md
# regfile_np

Parametrised multi-port register file: DEPTH words of WIDTH bits, one synchronous write port and NRD independent combinational read ports. Each read port is a log2(DEPTH)-level tree of 2:1 word muxes; the write side is an address decoder and enable-gated word registers. It sits in the decode stage of the single-cycle datapath and generalises the fixed 32-entry, 64-bit read mux to any power-of-two depth and any read-port count. It also provides a hardwired zero register and an optional write-through bypass.

## Interface
Parameters:
- WIDTH, 64: bits per word.
- DEPTH, 32: number of words; power of two, ≥ 2.
- NRD, 2: number of read ports, ≥ 1.
- ZERO_IDX, 31: index of the hardwired-zero register; any value ≥ DEPTH disables the zero register.
- AW (localparam), $clog2(DEPTH): address width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clk.
- wr_en  in  1  write enable.
- wr_addr  in  AW  write address.
- wr_data  in  WIDTH  write data.
- rd_addr  in  [NRD-1:0][AW-1:0]  read address, one per port.
- rd_data  out  [NRD-1:0][WIDTH-1:0]  read data, one per port.

## Operation
- Storage: DEPTH word registers, mem[0..DEPTH-1].
- Write:
  - At a rising edge with wr_en=1 and reset=0, mem[wr_addr] <= wr_data.
  - All other words hold their value.
  - A write to ZERO_IDX is discarded; that register is never updated.
- Read:
  - Combinationally, rd_data[p] = mem[rd_addr[p]].
  - rd_data[p] is forced to 0 when rd_addr[p] == ZERO_IDX, regardless of storage or bypass.
- Ports are independent:
  - Any number of ports may read the same address in the same cycle.
  - All such ports return identical data.
- Reset: while reset=1 at a rising edge, every word is cleared to 0 and any concurrent write is ignored.
- Outputs have no reset value of their own. During and after reset they reflect cleared storage, so all rd_data read 0 after the reset edge.

## Timing
- Write latency: data written at edge N is visible on rd_data from just after edge N (same cycle, combinationally after the clock-to-q delay).
- Read latency: combinational, zero cycles. rd_data follows rd_addr within the mux-tree delay of AW 2:1 stages.
- Same-address read and write in one cycle, without bypass: rd_data shows the old value until the edge, then the new value.
- Back-to-back writes to one address: the last write wins at each edge.
- Reset mid-stream:
  - A reset asserted in the same cycle as wr_en=1 cancels that write.
  - Writes resume on the first edge with reset=0.
- No handshake. The write port accepts every cycle; it never stalls or backpressures.

## Configuration
- Macro: REGFILE_BYPASS_EN.
- Defined: write-through forwarding.
  - When wr_en=1, reset=0, wr_addr != ZERO_IDX and rd_addr[p] == wr_addr, rd_data[p] = wr_data combinationally in the same cycle, before the edge.
  - This lets a single-cycle or pipelined datapath read a result in its write cycle.
  - Bypass is suppressed during reset and for the zero register.
- Undefined: no forwarding. Reads always return the stored value, as described under Timing.

## Test plan
- Reset clear: preload mem[3]=64'hDEAD, pulse reset=1 for one edge with wr_en=1, wr_addr=5, wr_data=7 -> on all ports, rd_addr=3 reads 0 and rd_addr=5 reads 0.
- Full sweep: write mem[k]=k*64'd1000+1 for k=0..30, then step rd_addr[0] over 0..31 and rd_addr[1] over 31..0 -> each port reads the written value, and index 31 reads 0 on both ports.
- Zero register: write 64'hFFFF_FFFF_FFFF_FFFF to addr 31 -> rd_data reads 0 both in that cycle and after the edge.
- Same-cycle read/write: mem[4]=10; in one cycle drive wr_en=1, wr_addr=4, wr_data=99, rd_addr[0]=4 ->
  - before the edge, reads 99 with REGFILE_BYPASS_EN defined and 10 without;
  - after the edge, reads 99 in both builds.
- Port independence: set all NRD ports to addr 7 (mem[7]=64'd538129) -> every port reads 538129; change port 0 to addr 2 -> port 0 changes and the others hold.
- Parametrisation: build with WIDTH=32, DEPTH=16, NRD=3, ZERO_IDX=16 (zero register disabled), repeat the full sweep -> all 16 entries, including index 15, are writable and read back correctly.
